pipe_stage_reg: RTL

- Generic, parametrised inter-stage pipeline register. Successor to the fixed-field EX/MEM register; used for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries separate control and data payloads with a valid/ready handshake, flush and an optional skid buffer.
- Control bits are zeroed whenever the stage holds a bubble, so downstream write/memory enables can never fire spuriously.
- Includes a saturating stall-cycle counter for performance bring-up.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_entry_reg.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: per-stage payload structs and stage occupancy encoding.
package pipe_pkg;

    // EX/MEM control payload, packed MSB-first as the stage expects it.
    typedef struct packed {
        logic       reg_wrt;
        logic       mem_wrt;
        logic       read;
        logic [1:0] rslt_src;
        logic [2:0] funct3;
    } exme_ctrl_t;

    // EX/MEM data payload.
    typedef struct packed {
        logic [31:0] alu_rslt;
        logic [31:0] wrt_d;
        logic [31:0] pc4;
        logic [31:0] uj_wrt_bck;
        logic [4:0]  rd;
    } exme_data_t;

    localparam int unsigned EXME_CTRL_W = $bits(exme_ctrl_t);
    localparam int unsigned EXME_DATA_W = $bits(exme_data_t);

    // Number of entries held by a skid-buffered stage.
    typedef enum logic [1:0] {
        OccEmpty,
        OccFull1,
        OccFull2
    } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot: valid flag, control and data payload.
// Clearing drops valid and zeroes control so a bubble never carries live enables;
// data is left as-is.
module pipe_entry_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 165
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next slot contents: load wins over clear, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            ctrl_d  = d_ctrl;
            data_d  = d_data;
        end else if (clr) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    // Slot storage with asynchronous reset to an empty, all-zero slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = EXME_CTRL_W,
    parameter int unsigned DATA_W = EXME_DATA_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Head slot; its outputs are the stage outputs, so out_ctrl comes straight from flops.
    pipe_entry_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clr   (main_clr),
        .d_ctrl(main_d_ctrl),
        .d_data(main_d_data),
        .valid (out_valid),
        .ctrl  (out_ctrl),
        .data  (out_data)
    );

    if (SKID != 0) begin : g_skid
        occ_e              occ_q, occ_d;
        logic              in_ready_q, in_ready_d;
        logic              skid_load;
        logic              skid_clr;
        logic              main_from_skid;
        logic              skid_valid;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        pipe_entry_reg #(
            .CTRL_W(CTRL_W),
            .DATA_W(DATA_W)
        ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clr   (skid_clr),
            .d_ctrl(in_ctrl),
            .d_data(in_data),
            .valid (skid_valid),
            .ctrl  (skid_ctrl),
            .data  (skid_data)
        );

        // Occupancy FSM: steers entries between input, head and skid slots; flush empties all.
        always_comb begin
            occ_d          = occ_q;
            main_load      = 1'b0;
            main_clr       = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
            skid_clr       = 1'b0;
            case (occ_q)
                OccEmpty: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        occ_d     = OccFull1;
                    end
                end
                OccFull1: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        occ_d     = OccFull2;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        occ_d    = OccEmpty;
                    end
                end
                OccFull2: begin
                    // in_ready is low here, so only the head can move.
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        occ_d          = OccFull1;
                    end
                end
                default: occ_d = OccEmpty;
            endcase
            if (flush) begin
                main_load = 1'b0;
                skid_load = 1'b0;
                main_clr  = 1'b1;
                skid_clr  = 1'b1;
                occ_d     = OccEmpty;
            end
            main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
            main_d_data = main_from_skid ? skid_data : in_data;
            // Registered ready: no combinational path from out_ready.
            in_ready_d  = (occ_d != OccFull2);
        end

        // Occupancy state and registered ready; ready is high while reset is held.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_q      <= OccEmpty;
                in_ready_q <= 1'b1;
            end else begin
                occ_q      <= occ_d;
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_single
        assign in_ready = out_ready | ~out_valid;

        // Single slot: load on in-transfer, else empty on out-transfer; flush kills the load.
        always_comb begin
            main_load   = in_xfer & ~flush;
            main_clr    = out_xfer | flush;
            main_d_ctrl = in_ctrl;
            main_d_data = in_data;
        end
    end

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where the head is blocked downstream; clear wins, saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
